// File: rtl/ysyx_22040759_ifu_if.sv
// Fetch-side bundle: instruction memory port, execute redirect and decode handshake.
interface ysyx_22040759_ifu_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [63:0] id_pc;

  modport master (
    output imem_req_valid, imem_req_addr, id_valid, id_inst, id_pc,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, id_valid, id_inst, id_pc,
    output imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/ysyx_22040759_ifu.sv
// Instruction fetch unit: credit-limited in-order fetch into a small registered FIFO,
// with redirect flush and dropping of stale in-flight responses.
module ysyx_22040759_ifu #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000,
  parameter int          DEPTH    = 4
) (
  input logic                  clk,
  input logic                  rst,
  ysyx_22040759_ifu_if.master  bus
);

  localparam int            AW     = $clog2(DEPTH);
  localparam int            CW     = $clog2(DEPTH + 1);
  localparam logic [CW:0]   CREDIT = (CW + 1)'(DEPTH);

  logic [63:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [AW-1:0] pcq_head_q, pcq_head_d, pcq_tail_q, pcq_tail_d;
  logic [63:0]   fifo_pc_q   [DEPTH];
  logic [63:0]   fifo_pc_d   [DEPTH];
  logic [31:0]   fifo_inst_q [DEPTH];
  logic [31:0]   fifo_inst_d [DEPTH];
  logic [63:0]   pcq_q       [DEPTH];
  logic [63:0]   pcq_d       [DEPTH];

  logic req_fire;
  logic push;
  logic pop;

  // Credits cover both buffered and in-flight words, so the FIFO can never overflow.
  assign bus.imem_req_valid = !rst && !bus.redirect_valid &&
                              (({1'b0, inflight_q} + {1'b0, count_q}) < CREDIT);
  assign bus.imem_req_addr  = fetch_pc_q;
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

  assign bus.id_valid = (count_q != '0);
  assign bus.id_inst  = fifo_inst_q[head_q];
  assign bus.id_pc    = fifo_pc_q[head_q];

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    inflight_d  = inflight_q + CW'(req_fire) - CW'(bus.imem_resp_valid);
    drop_cnt_d  = drop_cnt_q;
    count_d     = count_q;
    head_d      = head_q;
    tail_d      = tail_q;
    pcq_head_d  = pcq_head_q;
    pcq_tail_d  = pcq_tail_q;
    fifo_pc_d   = fifo_pc_q;
    fifo_inst_d = fifo_inst_q;
    pcq_d       = pcq_q;
    push        = 1'b0;
    pop         = 1'b0;

    // The address queue pairs every response with its request, stale or not.
    if (req_fire) begin
      pcq_d[pcq_tail_q] = fetch_pc_q;
      pcq_tail_d        = pcq_tail_q + AW'(1);
    end
    if (bus.imem_resp_valid) begin
      pcq_head_d = pcq_head_q + AW'(1);
    end

    if (bus.redirect_valid) begin
      fetch_pc_d = bus.redirect_pc & ~64'd3;
      drop_cnt_d = inflight_q - CW'(bus.imem_resp_valid);
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + 64'd4;
      end
      if (bus.imem_resp_valid) begin
        if (drop_cnt_q != '0) begin
          drop_cnt_d = drop_cnt_q - CW'(1);
        end else begin
          push = 1'b1;
        end
      end
      pop = bus.id_valid && bus.id_ready;
      if (push) begin
        fifo_pc_d[tail_q]   = pcq_q[pcq_head_q];
        fifo_inst_d[tail_q] = bus.imem_resp_data;
        tail_d              = tail_q + AW'(1);
      end
      if (pop) begin
        head_d = head_q + AW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      inflight_q <= '0;
      drop_cnt_q <= '0;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      pcq_head_q <= '0;
      pcq_tail_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_pc_q[i]   <= '0;
        fifo_inst_q[i] <= '0;
        pcq_q[i]       <= '0;
      end
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      inflight_q  <= inflight_d;
      drop_cnt_q  <= drop_cnt_d;
      count_q     <= count_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      pcq_head_q  <= pcq_head_d;
      pcq_tail_q  <= pcq_tail_d;
      fifo_pc_q   <= fifo_pc_d;
      fifo_inst_q <= fifo_inst_d;
      pcq_q       <= pcq_d;
    end
  end

endmodule

// File: tb/tb_ysyx_22040759_ifu.sv
// Bench for the fetch unit: in-order memory model with random latency, expected
// instruction stream kept as a queue and checked by an independent monitor.
module tb_ysyx_22040759_ifu;
  localparam logic [63:0] RESET_PC = 64'h8000_0000;

  typedef struct {
    logic [63:0] addr;
    int          due;
  } req_t;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_req = 1'b1;

  always #5 clk = ~clk;

  ysyx_22040759_ifu_if ifc ();

  ysyx_22040759_ifu #(.RESET_PC(RESET_PC), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_due = 0;
  int          lat_lo = 1;
  int          lat_hi = 1;
  int          acc_cnt = 0;
  int          cons_cnt = 0;
  int          first_acc = -1;
  int          first_vld = -1;
  req_t        mq[$];
  ent_t        exp_q[$];
  logic [63:0] cons_pcs[$];
  logic [63:0] gen_pc = RESET_PC;
  ent_t        mon_e;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0013;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, then note what the next rising edge will do.
  task automatic cycle(input logic rdy, input logic idr, input logic redir, input logic [63:0] tgt);
    int d;
    @(negedge clk);
    rst = rst_req;
    ifc.imem_resp_valid = 1'b0;
    ifc.imem_resp_data  = '0;
    if (rst) begin
      mq.delete();
      exp_q.delete();
      gen_pc   = RESET_PC;
      last_due = 0;
    end else if (mq.size() > 0 && mq[0].due <= cyc) begin
      ifc.imem_resp_valid = 1'b1;
      ifc.imem_resp_data  = mem_word(mq[0].addr);
      void'(mq.pop_front());
    end
    ifc.imem_req_ready = rdy;
    ifc.id_ready       = idr;
    ifc.redirect_valid = redir && !rst;
    ifc.redirect_pc    = tgt;
    if (ifc.redirect_valid) begin
      exp_q.delete();
      gen_pc = {tgt[63:2], 2'b00};
    end
    while (exp_q.size() < 8) begin
      exp_q.push_back('{gen_pc, mem_word(gen_pc)});
      gen_pc += 64'd4;
    end
    #1;
    if (ifc.imem_req_valid && ifc.imem_req_ready) begin
      d = cyc + int'($urandom_range(lat_hi, lat_lo));
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      mq.push_back('{ifc.imem_req_addr, d});
      acc_cnt++;
      if (first_acc < 0) first_acc = cyc;
    end
    if (!rst && ifc.id_valid && first_vld < 0) first_vld = cyc;
    if (!rst && ifc.id_valid && ifc.id_ready && !ifc.redirect_valid) begin
      cons_cnt++;
      cons_pcs.push_back(ifc.id_pc);
    end
    cyc++;
  endtask

  always @(negedge clk) begin
    #2;
    if (!rst && ifc.id_valid && ifc.id_ready && !ifc.redirect_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL id_stream: got pc=%h with nothing expected", ifc.id_pc);
      end else begin
        mon_e = exp_q.pop_front();
        if (ifc.id_pc !== mon_e.pc || ifc.id_inst !== mon_e.inst) begin
          errors++;
          $display("FAIL id_stream: got pc=%h inst=%h expected pc=%h inst=%h",
                   ifc.id_pc, ifc.id_inst, mon_e.pc, mon_e.inst);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int k;
    logic [63:0] exp_drop;
    logic [63:0] tgt;
    logic        redir;

    ifc.imem_req_ready  = 1'b0;
    ifc.imem_resp_valid = 1'b0;
    ifc.imem_resp_data  = '0;
    ifc.redirect_valid  = 1'b0;
    ifc.redirect_pc     = '0;
    ifc.id_ready        = 1'b0;

    // Reset values
    rst_req = 1'b1;
    repeat (3) cycle(1'b0, 1'b0, 1'b0, '0);
    chk("rst_req_valid", 64'(ifc.imem_req_valid), 64'd0);
    chk("rst_req_addr", ifc.imem_req_addr, RESET_PC);
    chk("rst_id_valid", 64'(ifc.id_valid), 64'd0);
    chk("rst_id_pc", ifc.id_pc, 64'd0);
    chk("rst_id_inst", 64'(ifc.id_inst), 64'd0);

    // Streaming after reset, L=1
    rst_req = 1'b0;
    lat_lo = 1; lat_hi = 1;
    first_acc = -1; first_vld = -1;
    cons_pcs.delete();
    cycle(1'b1, 1'b1, 1'b0, '0);
    chk("first_req_valid", 64'(ifc.imem_req_valid), 64'd1);
    chk("first_req_addr", ifc.imem_req_addr, RESET_PC);
    repeat (3) cycle(1'b1, 1'b1, 1'b0, '0);
    chk("first_id_latency", 64'(first_vld - first_acc), 64'd2);
    n = cons_cnt;
    repeat (8) cycle(1'b1, 1'b1, 1'b0, '0);
    chk("throughput", 64'(cons_cnt - n), 64'd8);
    chk("first_id_pc", cons_pcs[0], RESET_PC);

    // Back-pressure
    rst_req = 1'b1;
    repeat (2) cycle(1'b0, 1'b0, 1'b0, '0);
    rst_req = 1'b0;
    cons_pcs.delete();
    n = acc_cnt;
    repeat (10) cycle(1'b1, 1'b0, 1'b0, '0);
    chk("bp_accepts", 64'(acc_cnt - n), 64'd4);
    chk("bp_req_valid", 64'(ifc.imem_req_valid), 64'd0);
    chk("bp_id_pc", ifc.id_pc, RESET_PC);
    repeat (12) cycle(1'b1, 1'b1, 1'b0, '0);
    chk("bp_resume_pc", cons_pcs[4], RESET_PC + 64'd16);

    // Redirect with two requests in flight, L=3
    rst_req = 1'b1;
    repeat (2) cycle(1'b0, 1'b0, 1'b0, '0);
    rst_req = 1'b0;
    lat_lo = 3; lat_hi = 3;
    cons_pcs.delete();
    repeat (2) cycle(1'b1, 1'b1, 1'b0, '0);
    cycle(1'b1, 1'b1, 1'b1, 64'h8000_0100);
    cycle(1'b1, 1'b1, 1'b0, '0);
    chk("rd1_req_addr", ifc.imem_req_addr, 64'h8000_0100);
    chk("rd1_id_valid", 64'(ifc.id_valid), 64'd0);
    repeat (12) cycle(1'b1, 1'b1, 1'b0, '0);
    chk("rd1_pc0", cons_pcs[0], 64'h8000_0100);
    chk("rd1_pc1", cons_pcs[1], 64'h8000_0104);

    // Redirect coinciding with a response and a pop, L=2
    rst_req = 1'b1;
    repeat (2) cycle(1'b0, 1'b0, 1'b0, '0);
    rst_req = 1'b0;
    lat_lo = 2; lat_hi = 2;
    repeat (6) cycle(1'b1, 1'b1, 1'b0, '0);
    cons_pcs.delete();
    cycle(1'b1, 1'b1, 1'b1, 64'h8000_0203);
    chk("rd2_resp_same_cycle", 64'(ifc.imem_resp_valid), 64'd1);
    chk("rd2_pop_same_cycle", 64'(ifc.id_valid), 64'd1);
    exp_drop = 64'(mq.size());
    cycle(1'b1, 1'b1, 1'b0, '0);
    chk("rd2_drop_cnt", 64'(dut.drop_cnt_q), exp_drop);
    chk("rd2_req_addr", ifc.imem_req_addr, 64'h8000_0200);
    chk("rd2_id_valid", 64'(ifc.id_valid), 64'd0);
    repeat (10) cycle(1'b1, 1'b1, 1'b0, '0);
    chk("rd2_pc0", cons_pcs[0], 64'h8000_0200);

    // Back-to-back redirects
    repeat (3) cycle(1'b1, 1'b1, 1'b0, '0);
    cons_pcs.delete();
    cycle(1'b1, 1'b1, 1'b1, 64'h8000_0040);
    cycle(1'b1, 1'b1, 1'b1, 64'h8000_0080);
    repeat (12) cycle(1'b1, 1'b1, 1'b0, '0);
    chk("rd3_pc0", cons_pcs[0], 64'h8000_0080);
    chk("rd3_pc1", cons_pcs[1], 64'h8000_0084);

    // Random traffic, including an address-wrap redirect and sporadic redirects
    lat_lo = 1; lat_hi = 4;
    cycle(1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9);
    n = cons_cnt;
    k = 0;
    while ((cons_cnt - n) < 1000 && k < 20000) begin
      redir = ($urandom_range(99, 0) == 0);
      tgt   = {32'h0000_0000, 32'h8000_0000 | 32'($urandom_range(32'hFFFF, 0))};
      cycle(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), redir, tgt);
      k++;
    end
    chk("random_reached_1000", 64'((cons_cnt - n) >= 1000), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
